// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified instruction/data memory port arbiter:
//   default bus widths, starvation counter sizing and the response-select
//   encoding used by the arbiter's response FSM.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR       = 16;
  localparam int unsigned DEF_WORD       = 32;
  localparam int unsigned DEF_STARVE_MAX = 4;
  // Wide enough for the full 1..15 STARVE_MAX range.
  localparam int unsigned STARVE_W       = 4;

  // Kind of access granted last cycle, i.e. which response is due now.
  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_IF   = 2'd1,
    RS_LD   = 2'd2,
    RS_ST   = 2'd3
  } resp_sel_e;

  // Classify this cycle's grant into the response expected next cycle.
  // A fetch granted together with a flush still reaches memory, but its
  // response is never delivered.
  function automatic resp_sel_e grant_kind(input logic grant_if,
                                           input logic grant_ls,
                                           input logic ls_write,
                                           input logic flush);
    resp_sel_e kind;
    kind = RS_NONE;
    if (grant_ls) begin
      kind = ls_write ? RS_ST : RS_LD;
    end else if (grant_if) begin
      kind = flush ? RS_NONE : RS_IF;
    end else begin
      kind = RS_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch request/response, load/store request/response, branch
//   flush and single-port memory signals around the arbiter.
//   modport slave  : the arbiter's view (requests and mem_q_i in, grants,
//                    responses and memory drive out).
//   modport master : the view of the surrounding core and memory model.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR = DEF_ADDR,
  parameter int WORD = DEF_WORD
);

  logic            if_req_i;
  logic [ADDR-1:0] if_addr_i;
  logic            if_stall_o;
  logic            if_v_o;
  logic [WORD-1:0] if_data_o;
  logic            flush_i;

  logic            ls_req_i;
  logic            ls_write_i;
  logic [ADDR-1:0] ls_addr_i;
  logic [WORD-1:0] ls_wdata_i;
  logic            ls_stall_o;
  logic            ls_v_o;
  logic [WORD-1:0] ls_rdata_o;

  logic [ADDR-1:0] mem_a_o;
  logic            mem_w_o;
  logic [WORD-1:0] mem_d_o;
  logic [WORD-1:0] mem_q_i;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
    input  mem_q_i,
    output if_stall_o, if_v_o, if_data_o,
    output ls_stall_o, ls_v_o, ls_rdata_o,
    output mem_a_o, mem_w_o, mem_d_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
    output mem_q_i,
    input  if_stall_o, if_v_o, if_data_o,
    input  ls_stall_o, ls_v_o, ls_rdata_o,
    input  mem_a_o, mem_w_o, mem_d_o
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter
//   Counts consecutive cycles in which fetch is requesting but loses to
//   load/store. Once the count reaches STARVE_MAX, force_o tells the grant
//   logic to let fetch win the next contended cycle.
//   Ports: clk, reset (sync, active-high), if_req_i, ls_req_i,
//          grant_if_i (fetch granted this cycle), force_o.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req_i,
  input  logic ls_req_i,
  input  logic grant_if_i,
  output logic force_o
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_r;
  logic [STARVE_W-1:0] cnt_nxt_s;

  // Next count: clear once fetch is served or stops asking, saturate at max.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (grant_if_i || !if_req_i) begin
      cnt_nxt_s = '0;
    end else if (ls_req_i && (cnt_r != MAX_C)) begin
      cnt_nxt_s = cnt_r + STARVE_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign force_o = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory (1-cycle read latency) between
//   instruction fetch and the execute load/store path. One access is granted
//   per cycle; load/store normally wins, but fetch is forced through after
//   STARVE_MAX consecutive denials. The loser sees a same-cycle stall.
//   Responses are delivered the cycle after the grant, steered by resp_sel_r.
//   Ports: clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave:
//          fetch/load-store requests and responses, flush, memory A/W/D/Q).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR       = DEF_ADDR,
  parameter int WORD       = DEF_WORD,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  logic      force_if_s;
  logic      grant_if_s;
  logic      grant_ls_s;
  resp_sel_e resp_sel_r;
  resp_sel_e resp_sel_nxt_s;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .if_req_i   (bus.if_req_i),
    .ls_req_i   (bus.ls_req_i),
    .grant_if_i (grant_if_s),
    .force_o    (force_if_s)
  );

  // Grant selection: starved fetch first, then load/store, then fetch.
  always_comb begin
    grant_if_s = 1'b0;
    grant_ls_s = 1'b0;
    if (bus.if_req_i && bus.ls_req_i && force_if_s) begin
      grant_if_s = 1'b1;
    end else if (bus.ls_req_i) begin
      grant_ls_s = 1'b1;
    end else if (bus.if_req_i) begin
      grant_if_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
      grant_ls_s = 1'b0;
    end
  end

  assign bus.if_stall_o = bus.if_req_i & ~grant_if_s;
  assign bus.ls_stall_o = bus.ls_req_i & ~grant_ls_s;

  // Memory drive: address of the winner, write only on a granted store.
  always_comb begin
    bus.mem_a_o = '0;
    bus.mem_w_o = 1'b0;
    bus.mem_d_o = bus.ls_wdata_i;
    if (grant_ls_s) begin
      bus.mem_a_o = bus.ls_addr_i;
      bus.mem_w_o = bus.ls_write_i;
    end else if (grant_if_s) begin
      bus.mem_a_o = bus.if_addr_i;
    end else begin
      bus.mem_a_o = '0;
      bus.mem_w_o = 1'b0;
    end
  end

  // Response FSM next state: whatever was granted this cycle.
  always_comb begin
    resp_sel_nxt_s = grant_kind(grant_if_s, grant_ls_s, bus.ls_write_i, bus.flush_i);
  end

  // Response FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_sel_r <= RS_NONE;
    end else begin
      resp_sel_r <= resp_sel_nxt_s;
    end
  end

  // Response steering: mem_q_i belongs to last cycle's grant. A flush in the
  // response cycle still kills a fetch response.
  always_comb begin
    bus.if_v_o     = 1'b0;
    bus.if_data_o  = '0;
    bus.ls_v_o     = 1'b0;
    bus.ls_rdata_o = '0;
    case (resp_sel_r)
      RS_IF: begin
        bus.if_v_o    = ~bus.flush_i;
        bus.if_data_o = bus.mem_q_i;
      end
      RS_LD: begin
        bus.ls_v_o     = 1'b1;
        bus.ls_rdata_o = bus.mem_q_i;
      end
      RS_ST: begin
        bus.ls_v_o     = 1'b1;
        bus.ls_rdata_o = '0;
      end
      RS_NONE: begin
        bus.if_v_o = 1'b0;
        bus.ls_v_o = 1'b0;
      end
      default: begin
        bus.if_v_o = 1'b0;
        bus.ls_v_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter with a 256-word
//   read-first synchronous memory model on the memory side.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.ADDR(16), .WORD(32)) bus ();

  mem_port_arbiter #(
    .ADDR       (16),
    .WORD       (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:255];
  logic [31:0] q_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory model, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_w_o) mem[bus.mem_a_o[7:0]] <= bus.mem_d_o;
    q_r <= mem[bus.mem_a_o[7:0]];
  end
  assign bus.mem_q_i = q_r;

  task automatic idle();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 16'h0000;
    bus.flush_i    = 1'b0;
    bus.ls_req_i   = 1'b0;
    bus.ls_write_i = 1'b0;
    bus.ls_addr_i  = 16'h0000;
    bus.ls_wdata_i = 32'h0000_0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.if_v_o !== 1'b0) begin bad++; $display("FAIL reset_if_v got=%b exp=0", bus.if_v_o); end
    total++; if (bus.ls_v_o !== 1'b0) begin bad++; $display("FAIL reset_ls_v got=%b exp=0", bus.ls_v_o); end
    total++; if (bus.if_data_o !== 32'h0) begin bad++; $display("FAIL reset_if_data got=%h exp=0", bus.if_data_o); end
    total++; if (bus.ls_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_ls_rdata got=%h exp=0", bus.ls_rdata_o); end
    total++; if (bus.mem_w_o !== 1'b0) begin bad++; $display("FAIL reset_mem_w got=%b exp=0", bus.mem_w_o); end
    total++; if (bus.mem_a_o !== 16'h0) begin bad++; $display("FAIL reset_mem_a got=%h exp=0", bus.mem_a_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch_only();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 16'(i);
      end else begin
        bus.if_req_i = 1'b0;
      end
      #1;
      if (i < 3) begin
        total++;
        if (bus.if_stall_o !== 1'b0) begin bad++; $display("FAIL fetch_stall[%0d] got=%b exp=0", i, bus.if_stall_o); end
      end
      if (i > 0) begin
        exp = 32'h0000_00A0 + 32'(i - 1);
        total++;
        if (bus.if_v_o !== 1'b1) begin bad++; $display("FAIL fetch_v[%0d] got=%b exp=1", i, bus.if_v_o); end
        total++;
        if (bus.if_data_o !== exp) begin bad++; $display("FAIL fetch_data[%0d] got=%h exp=%h", i, bus.if_data_o, exp); end
      end
    end
    idle();
  endtask

  task automatic test_contention();
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0010;
    bus.ls_req_i = 1'b1; bus.ls_write_i = 1'b0; bus.ls_addr_i = 16'h0020;
    #1;
    total++; if (bus.ls_stall_o !== 1'b0) begin bad++; $display("FAIL cont_ls_stall got=%b exp=0", bus.ls_stall_o); end
    total++; if (bus.if_stall_o !== 1'b1) begin bad++; $display("FAIL cont_if_stall got=%b exp=1", bus.if_stall_o); end
    total++; if (bus.mem_a_o !== 16'h0020) begin bad++; $display("FAIL cont_mem_a got=%h exp=0020", bus.mem_a_o); end
    @(negedge clk);
    bus.ls_req_i = 1'b0;
    #1;
    total++; if (bus.ls_v_o !== 1'b1) begin bad++; $display("FAIL cont_ls_v got=%b exp=1", bus.ls_v_o); end
    total++; if (bus.ls_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL cont_ls_rdata got=%h exp=deadbeef", bus.ls_rdata_o); end
    total++; if (bus.if_stall_o !== 1'b0) begin bad++; $display("FAIL cont_if_grant got=%b exp=0", bus.if_stall_o); end
    total++; if (bus.mem_a_o !== 16'h0010) begin bad++; $display("FAIL cont_if_addr got=%h exp=0010", bus.mem_a_o); end
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.if_v_o !== 1'b1) begin bad++; $display("FAIL cont_if_v got=%b exp=1", bus.if_v_o); end
    total++; if (bus.if_data_o !== 32'h0000_1010) begin bad++; $display("FAIL cont_if_data got=%h exp=00001010", bus.if_data_o); end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    bus.ls_req_i = 1'b1; bus.ls_write_i = 1'b1; bus.ls_addr_i = 16'h0030; bus.ls_wdata_i = 32'h1234_5678;
    #1;
    total++; if (bus.mem_w_o !== 1'b1) begin bad++; $display("FAIL st_mem_w got=%b exp=1", bus.mem_w_o); end
    total++; if (bus.mem_d_o !== 32'h1234_5678) begin bad++; $display("FAIL st_mem_d got=%h exp=12345678", bus.mem_d_o); end
    @(negedge clk);
    bus.ls_write_i = 1'b0;
    #1;
    total++; if (bus.mem_w_o !== 1'b0) begin bad++; $display("FAIL ld_mem_w got=%b exp=0", bus.mem_w_o); end
    total++; if (bus.ls_v_o !== 1'b1) begin bad++; $display("FAIL st_ack_v got=%b exp=1", bus.ls_v_o); end
    total++; if (bus.ls_rdata_o !== 32'h0) begin bad++; $display("FAIL st_ack_rdata got=%h exp=0", bus.ls_rdata_o); end
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.ls_v_o !== 1'b1) begin bad++; $display("FAIL ld_v got=%b exp=1", bus.ls_v_o); end
    total++; if (bus.ls_rdata_o !== 32'h1234_5678) begin bad++; $display("FAIL ld_rdata got=%h exp=12345678", bus.ls_rdata_o); end
    @(negedge clk);
    #1;
    total++; if (bus.ls_v_o !== 1'b0) begin bad++; $display("FAIL idle_ls_v got=%b exp=0", bus.ls_v_o); end
    total++; if (bus.mem_w_o !== 1'b0) begin bad++; $display("FAIL idle_mem_w got=%b exp=0", bus.mem_w_o); end
  endtask

  // Both requesters held; fetch must win on cycles that are multiples of 5.
  task automatic starve_run(input string tag, input int cycles);
    logic g;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0060;
      bus.ls_req_i = 1'b1; bus.ls_write_i = 1'b0; bus.ls_addr_i = 16'h0070;
      #1;
      g = ((c % 5) == 0);
      total++; if (bus.if_stall_o !== ~g) begin bad++; $display("FAIL %s_if_stall[%0d] got=%b exp=%b", tag, c, bus.if_stall_o, ~g); end
      total++; if (bus.ls_stall_o !== g) begin bad++; $display("FAIL %s_ls_stall[%0d] got=%b exp=%b", tag, c, bus.ls_stall_o, g); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_starvation();
    starve_run("starve", 10);
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0040; bus.flush_i = 1'b1;
    #1;
    total++; if (bus.if_stall_o !== 1'b0) begin bad++; $display("FAIL flush_grant got=%b exp=0", bus.if_stall_o); end
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.if_v_o !== 1'b0) begin bad++; $display("FAIL flush_grant_v got=%b exp=0", bus.if_v_o); end
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0041;
    @(negedge clk);
    idle();
    bus.flush_i = 1'b1;
    #1;
    total++; if (bus.if_v_o !== 1'b0) begin bad++; $display("FAIL flush_resp_v got=%b exp=0", bus.if_v_o); end
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0042;
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.if_v_o !== 1'b1) begin bad++; $display("FAIL noflush_v got=%b exp=1", bus.if_v_o); end
    total++; if (bus.if_data_o !== 32'h0000_4242) begin bad++; $display("FAIL noflush_data got=%h exp=00004242", bus.if_data_o); end
    @(negedge clk);
    bus.ls_req_i = 1'b1; bus.ls_addr_i = 16'h0020; bus.flush_i = 1'b1;
    @(negedge clk);
    idle();
    bus.flush_i = 1'b1;
    #1;
    total++; if (bus.ls_v_o !== 1'b1) begin bad++; $display("FAIL flush_ls_v got=%b exp=1", bus.ls_v_o); end
    total++; if (bus.ls_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL flush_ls_rdata got=%h exp=deadbeef", bus.ls_rdata_o); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0050;
    bus.ls_req_i = 1'b1; bus.ls_write_i = 1'b0; bus.ls_addr_i = 16'h0020;
    #1;
    total++; if (bus.ls_stall_o !== 1'b0) begin bad++; $display("FAIL rst_ld_grant got=%b exp=0", bus.ls_stall_o); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    total++; if (bus.ls_v_o !== 1'b0) begin bad++; $display("FAIL rst_ls_v got=%b exp=0", bus.ls_v_o); end
    total++; if (bus.if_v_o !== 1'b0) begin bad++; $display("FAIL rst_if_v got=%b exp=0", bus.if_v_o); end
    total++; if (bus.mem_w_o !== 1'b0) begin bad++; $display("FAIL rst_mem_w got=%b exp=0", bus.mem_w_o); end
    total++; if (bus.mem_a_o !== 16'h0) begin bad++; $display("FAIL rst_mem_a got=%h exp=0", bus.mem_a_o); end
    // Starvation count must restart from zero: four load/store wins first.
    starve_run("rst_starve", 5);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0000_00A0;
    mem[1]    = 32'h0000_00A1;
    mem[2]    = 32'h0000_00A2;
    mem[8'h10] = 32'h0000_1010;
    mem[8'h20] = 32'hDEADBEEF;
    mem[8'h42] = 32'h0000_4242;
    test_reset();
    test_fetch_only();
    test_contention();
    test_store_load();
    test_starvation();
    test_flush();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
